// File: rtl/sr_cmd_if.sv
// Command bundle between the raw set/clear sources and the SR conditioner.
interface sr_cmd_if;
  logic set_raw;
  logic clr_raw;
  logic enable;
  logic s;
  logic r;
  logic q_track;
  logic conflict;
  logic busy;

  modport master (
    output set_raw, clr_raw, enable,
    input  s, r, q_track, conflict, busy
  );

  modport slave (
    input  set_raw, clr_raw, enable,
    output s, r, q_track, conflict, busy
  );
endinterface

// File: rtl/sr_cmd_conditioner.sv
// Synchronizes and debounces raw set/clear requests and issues clean,
// mutually exclusive one-cycle s/r pulses for the downstream SR flip-flop.
// Index 0 of every per-input vector is the set path, index 1 the clear path.
module sr_cmd_conditioner #(
  parameter int unsigned DEB_CYCLES   = 4,
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned GUARD_CYCLES = 1,
  parameter bit          PRIO_CLR     = 1'b1
) (
  input  logic     clk,
  input  logic     rst,
  sr_cmd_if.slave  cmd
);

  localparam int unsigned GW = 4;

  typedef enum logic [1:0] {IDLE, PULSE, GUARD} state_t;

  logic [1:0]       r_sync1;
  logic [1:0]       r_sync2;
  logic [1:0]       r_deb;
  logic [1:0]       r_deb_d;
  logic [CNT_W-1:0] r_cnt [2];
  logic [1:0]       r_pend;
  logic [GW-1:0]    r_gcnt;
  state_t           r_state;
  logic             r_s;
  logic             r_r;
  logic             r_q;
  logic             r_cf;
  logic             r_busy;

  logic [1:0]       w_req;
  logic [1:0]       w_work;
  logic             w_issue;
  state_t           w_state_nxt;
  logic [1:0]       w_pend_nxt;
  logic [GW-1:0]    w_gcnt_nxt;
  logic             w_s_nxt;
  logic             w_r_nxt;
  logic             w_q_nxt;
  logic             w_cf_nxt;

  // Two-flop synchronizers on both raw request lines.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= {cmd.clr_raw, cmd.set_raw};
      r_sync2 <= r_sync1;
    end
  end

  // Debounce: level flips only after DEB_CYCLES consecutive differing samples.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_deb   <= '0;
      r_deb_d <= '0;
      for (int i = 0; i < 2; i++) r_cnt[i] <= '0;
    end else begin
      r_deb_d <= r_deb;
      for (int i = 0; i < 2; i++) begin
        if (r_sync2[i] != r_deb[i]) begin
          if (r_cnt[i] == CNT_W'(DEB_CYCLES - 1)) begin
            r_deb[i] <= ~r_deb[i];
            r_cnt[i] <= '0;
          end else begin
            r_cnt[i] <= r_cnt[i] + CNT_W'(1);
          end
        end else begin
          r_cnt[i] <= '0;
        end
      end
    end
  end

  // Rising debounced edges become requests only while enabled.
  assign w_req  = r_deb & ~r_deb_d & {2{cmd.enable}};
  assign w_work = r_pend | w_req;

  // Next-state, pending bookkeeping and pulse selection.
  always_comb begin
    w_state_nxt = r_state;
    w_pend_nxt  = r_pend;
    w_gcnt_nxt  = r_gcnt;
    w_s_nxt     = 1'b0;
    w_r_nxt     = 1'b0;
    w_q_nxt     = r_q;
    w_cf_nxt    = 1'b0;
    w_issue     = 1'b0;

    case (r_state)
      IDLE: begin
        if (|w_work) w_issue = 1'b1;
      end
      PULSE: begin
        if (GUARD_CYCLES > 0) begin
          w_state_nxt = GUARD;
          w_gcnt_nxt  = '0;
          w_pend_nxt  = w_work;
        end else if (|w_work) begin
          // No guard: alternating pulses may follow back to back.
          w_issue = 1'b1;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      GUARD: begin
        w_pend_nxt = w_work;
        if (r_gcnt == GW'(GUARD_CYCLES - 1)) begin
          w_state_nxt = IDLE;
        end else begin
          w_gcnt_nxt = r_gcnt + GW'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    if (w_issue) begin
      // Winner is issued; the loser of a collision is dropped with the winner.
      w_state_nxt = PULSE;
      w_pend_nxt  = '0;
      if (&w_work) begin
        w_cf_nxt = 1'b1;
        w_r_nxt  = PRIO_CLR;
        w_s_nxt  = ~PRIO_CLR;
      end else begin
        w_r_nxt  = w_work[1];
        w_s_nxt  = w_work[0];
      end
      w_q_nxt = w_s_nxt;
    end
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_pend  <= '0;
      r_gcnt  <= '0;
      r_s     <= 1'b0;
      r_r     <= 1'b0;
      r_q     <= 1'b0;
      r_cf    <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pend  <= w_pend_nxt;
      r_gcnt  <= w_gcnt_nxt;
      r_s     <= w_s_nxt;
      r_r     <= w_r_nxt;
      r_q     <= w_q_nxt;
      r_cf    <= w_cf_nxt;
      r_busy  <= (w_state_nxt != IDLE);
    end
  end

  assign cmd.s        = r_s;
  assign cmd.r        = r_r;
  assign cmd.q_track  = r_q;
  assign cmd.conflict = r_cf;
  assign cmd.busy     = r_busy;

endmodule
